// File: rtl/ssp_tx_fifo_param.sv
// ssp_tx_fifo_param: parametrised SSP transmit FIFO between the APB write side
// and the serial transmit shifter.
//
// Optional feature: define SSP_TXFIFO_ERR_FLAGS_EN to build the sticky
// overflow/underrun flags; otherwise both outputs are tied low and err_clr is
// ignored.
//
// Ports:
//   pclk, clear_b       clock, async active-low reset
//   psel, pwrite        write qualifier and strobe
//   pwdata              write data
//   t_en                read request from the shifter (not gated by psel)
//   err_clr             synchronous clear of the sticky error flags
//   txdata              last word read (registered, holds between reads)
//   ready               FIFO non-empty
//   ssptxintr           FIFO full
//   almost_full         count >= AFULL_LEVEL
//   count               occupancy, 0..DEPTH
//   overflow, underrun  sticky error flags
module ssp_tx_fifo_param #(
  parameter int unsigned DATA_WIDTH  = 8,
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned AFULL_LEVEL = DEPTH - 1,
  localparam int unsigned CW         = $clog2(DEPTH + 1)
) (
  input  logic                  pclk,
  input  logic                  clear_b,
  input  logic                  psel,
  input  logic                  pwrite,
  input  logic [DATA_WIDTH-1:0] pwdata,
  input  logic                  t_en,
  input  logic                  err_clr,
  output logic [DATA_WIDTH-1:0] txdata,
  output logic                  ready,
  output logic                  ssptxintr,
  output logic                  almost_full,
  output logic [CW-1:0]         count,
  output logic                  overflow,
  output logic                  underrun
);

  localparam int unsigned PW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wptr_q, wptr_d;
  logic [PW-1:0]         rptr_q, rptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic [DATA_WIDTH-1:0] txdata_q, txdata_d;
  logic                  ready_q, ready_d;
  logic                  full_q, full_d;
  logic                  afull_q, afull_d;
  logic                  rd_c, wr_c;

  // Accept decode, pointer/count update; flags are registered from the next count
  always_comb begin
    rd_c     = t_en && (count_q != '0);
    wr_c     = psel && pwrite && ((count_q != CW'(DEPTH)) || rd_c);
    wptr_d   = wptr_q;
    rptr_d   = rptr_q;
    count_d  = count_q;
    txdata_d = txdata_q;
    if (rd_c) begin
      txdata_d = mem_q[rptr_q];
      rptr_d   = rptr_q + PW'(1);
    end
    if (wr_c) begin
      wptr_d = wptr_q + PW'(1);
    end
    case ({wr_c, rd_c})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ready_d = (count_d != '0);
    full_d  = (count_d == CW'(DEPTH));
    afull_d = (count_d >= CW'(AFULL_LEVEL));
  end

  // Storage is not reset; contents only become visible through an accepted read
  always_ff @(posedge pclk) begin
    if (wr_c) begin
      mem_q[wptr_q] <= pwdata;
    end
  end

  // Control state
  always_ff @(posedge pclk or negedge clear_b) begin
    if (!clear_b) begin
      wptr_q   <= '0;
      rptr_q   <= '0;
      count_q  <= '0;
      txdata_q <= '0;
      ready_q  <= 1'b0;
      full_q   <= 1'b0;
      afull_q  <= 1'b0;
    end else begin
      wptr_q   <= wptr_d;
      rptr_q   <= rptr_d;
      count_q  <= count_d;
      txdata_q <= txdata_d;
      ready_q  <= ready_d;
      full_q   <= full_d;
      afull_q  <= afull_d;
    end
  end

  assign txdata      = txdata_q;
  assign count       = count_q;
  assign ready       = ready_q;
  assign ssptxintr   = full_q;
  assign almost_full = afull_q;

`ifdef SSP_TXFIFO_ERR_FLAGS_EN
  logic overflow_q, overflow_d;
  logic underrun_q, underrun_d;

  // Sticky flags; a set condition beats err_clr in the same cycle
  always_comb begin
    overflow_d = (psel && pwrite && (count_q == CW'(DEPTH)) && !rd_c)
                 || (overflow_q && !err_clr);
    underrun_d = (t_en && (count_q == '0)) || (underrun_q && !err_clr);
  end

  always_ff @(posedge pclk or negedge clear_b) begin
    if (!clear_b) begin
      overflow_q <= 1'b0;
      underrun_q <= 1'b0;
    end else begin
      overflow_q <= overflow_d;
      underrun_q <= underrun_d;
    end
  end

  assign overflow = overflow_q;
  assign underrun = underrun_q;
`else
  logic unused_err_clr;
  assign unused_err_clr = err_clr;
  assign overflow       = 1'b0;
  assign underrun       = 1'b0;
`endif

endmodule

// File: tb/tb_ssp_tx_fifo_param.sv
module tb_ssp_tx_fifo_param;

`ifdef SSP_TXFIFO_ERR_FLAGS_EN
  localparam logic ERR = 1'b1;
`else
  localparam logic ERR = 1'b0;
`endif

  logic        pclk = 1'b0;
  logic        clear_b;
  // default-parameter instance (8 bits x 4)
  logic        psel, pwrite, t_en, err_clr;
  logic [7:0]  pwdata, txdata;
  logic        ready, ssptxintr, almost_full, overflow, underrun;
  logic [2:0]  count;
  // wide instance (16 bits x 8, almost-full at 6)
  logic        w_psel, w_pwrite, w_t_en, w_err_clr;
  logic [15:0] w_pwdata, w_txdata;
  logic        w_ready, w_ssptxintr, w_almost_full, w_overflow, w_underrun;
  logic [3:0]  w_count;

  int checks = 0;
  int errors = 0;

  always #5 pclk = ~pclk;

  ssp_tx_fifo_param u_dut (
    .pclk(pclk), .clear_b(clear_b), .psel(psel), .pwrite(pwrite),
    .pwdata(pwdata), .t_en(t_en), .err_clr(err_clr), .txdata(txdata),
    .ready(ready), .ssptxintr(ssptxintr), .almost_full(almost_full),
    .count(count), .overflow(overflow), .underrun(underrun)
  );

  ssp_tx_fifo_param #(.DATA_WIDTH(16), .DEPTH(8), .AFULL_LEVEL(6)) u_wide (
    .pclk(pclk), .clear_b(clear_b), .psel(w_psel), .pwrite(w_pwrite),
    .pwdata(w_pwdata), .t_en(w_t_en), .err_clr(w_err_clr), .txdata(w_txdata),
    .ready(w_ready), .ssptxintr(w_ssptxintr), .almost_full(w_almost_full),
    .count(w_count), .overflow(w_overflow), .underrun(w_underrun)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // advance one edge and settle
  task automatic cyc();
    @(posedge pclk);
    #1;
  endtask

  task automatic drive(input logic wr, input logic [7:0] d, input logic rd, input logic ec);
    psel = wr; pwrite = wr; pwdata = d; t_en = rd; err_clr = ec;
  endtask

  task automatic state(input string tag, input logic [7:0] tx, input logic [2:0] cnt,
                       input logic rdy, input logic full, input logic af);
    chk({tag, ".txdata"}, 32'(txdata), 32'(tx));
    chk({tag, ".count"}, 32'(count), 32'(cnt));
    chk({tag, ".ready"}, 32'(ready), 32'(rdy));
    chk({tag, ".ssptxintr"}, 32'(ssptxintr), 32'(full));
    chk({tag, ".almost_full"}, 32'(almost_full), 32'(af));
  endtask

  initial begin
    logic [15:0] sb[$];
    logic [15:0] exp_tx;
    int          m;
    int          written;
    logic        wv, rv, rd_m, wr_m;
    logic [15:0] dv;

    clear_b = 1'b0;
    drive(1'b0, 8'h00, 1'b0, 1'b0);
    w_psel = 0; w_pwrite = 0; w_pwdata = '0; w_t_en = 0; w_err_clr = 0;
    repeat (2) cyc();
    state("reset", 8'h00, 3'd0, 0, 0, 0);
    chk("reset.overflow", 32'(overflow), 0);
    chk("reset.underrun", 32'(underrun), 0);
    chk("reset.w_count", 32'(w_count), 0);
    clear_b = 1'b1;
    cyc();

    // fill 0x11..0x44
    drive(1, 8'h11, 0, 0); cyc(); state("fill1", 8'h00, 3'd1, 1, 0, 0);
    drive(1, 8'h22, 0, 0); cyc(); state("fill2", 8'h00, 3'd2, 1, 0, 0);
    drive(1, 8'h33, 0, 0); cyc(); state("fill3", 8'h00, 3'd3, 1, 0, 1);
    drive(1, 8'h44, 0, 0); cyc(); state("fill4", 8'h00, 3'd4, 1, 1, 1);
    chk("fill4.overflow", 32'(overflow), 0);
    drive(1, 8'h55, 0, 0); cyc(); state("drop55", 8'h00, 3'd4, 1, 1, 1);
    chk("drop55.overflow", 32'(overflow), 32'(ERR));
    drive(0, 8'h00, 0, 1); cyc();
    chk("ovf_clr.overflow", 32'(overflow), 0);

    // drain with t_en held
    drive(0, 8'h00, 1, 0); cyc(); state("drain1", 8'h11, 3'd3, 1, 0, 1);
    cyc(); state("drain2", 8'h22, 3'd2, 1, 0, 0);
    cyc(); state("drain3", 8'h33, 3'd1, 1, 0, 0);
    chk("drain3.underrun", 32'(underrun), 0);
    cyc(); state("drain4", 8'h44, 3'd0, 0, 0, 0);
    chk("drain4.underrun", 32'(underrun), 0);
    cyc(); state("under", 8'h44, 3'd0, 0, 0, 0);
    chk("under.underrun", 32'(underrun), 32'(ERR));
    // set condition beats clear
    drive(0, 8'h00, 1, 1); cyc();
    chk("setwins.underrun", 32'(underrun), 32'(ERR));
    drive(0, 8'h00, 0, 1); cyc();
    chk("udr_clr.underrun", 32'(underrun), 0);

    // full with simultaneous read and write, wrap check
    drive(1, 8'h11, 0, 0); cyc();
    drive(1, 8'h22, 0, 0); cyc();
    drive(1, 8'h33, 0, 0); cyc();
    drive(1, 8'h44, 0, 0); cyc(); state("refill", 8'h44, 3'd4, 1, 1, 1);
    drive(1, 8'hAA, 1, 0); cyc(); state("fullrw", 8'h11, 3'd4, 1, 1, 1);
    chk("fullrw.overflow", 32'(overflow), 0);
    drive(0, 8'h00, 1, 0); cyc(); state("wrap1", 8'h22, 3'd3, 1, 0, 1);
    cyc(); state("wrap2", 8'h33, 3'd2, 1, 0, 0);
    cyc(); state("wrap3", 8'h44, 3'd1, 1, 0, 0);
    cyc(); state("wrap4", 8'hAA, 3'd0, 0, 0, 0);

    // empty with simultaneous read request and write
    drive(1, 8'h5A, 1, 0); cyc(); state("emptyrw", 8'hAA, 3'd1, 1, 0, 0);
    chk("emptyrw.underrun", 32'(underrun), 32'(ERR));
    drive(0, 8'h00, 1, 0); cyc(); state("read5a", 8'h5A, 3'd0, 0, 0, 0);

    // reset mid-stream: asynchronous, outputs clear before any edge
    drive(1, 8'h66, 0, 0); cyc();
    drive(1, 8'h67, 0, 0); cyc();
    @(negedge pclk);
    clear_b = 1'b0;
    #1;
    state("async_rst", 8'h00, 3'd0, 0, 0, 0);
    chk("async_rst.underrun", 32'(underrun), 0);
    drive(0, 8'h00, 0, 0);
    cyc();
    clear_b = 1'b1;
    cyc();
    state("post_rst", 8'h00, 3'd0, 0, 0, 0);
    chk("post_rst.underrun", 32'(underrun), 0);
    drive(1, 8'h77, 0, 0); cyc();
    drive(0, 8'h00, 1, 0); cyc(); state("post_rst_rd", 8'h77, 3'd0, 0, 0, 0);
    drive(0, 8'h00, 0, 0);

    // wide instance: 20 pseudo-random words with random read/write overlap
    m = 0; written = 0; exp_tx = '0;
    for (int c = 0; c < 400 && (written < 20 || m != 0); c++) begin
      wv = (written < 20) && ($urandom_range(0, 3) != 0);
      rv = (written >= 20) || ($urandom_range(0, 2) == 0);
      dv = 16'($urandom);
      w_psel = wv; w_pwrite = wv; w_pwdata = dv; w_t_en = rv;
      rd_m = rv && (m != 0);
      wr_m = wv && ((m != 8) || rd_m);
      cyc();
      if (rd_m) exp_tx = sb.pop_front();
      if (wr_m) begin sb.push_back(dv); written++; end
      if (wr_m && !rd_m) m++;
      else if (rd_m && !wr_m) m--;
      if (rd_m) chk("wide.txdata", 32'(w_txdata), 32'(exp_tx));
      chk("wide.count", 32'(w_count), 32'(m));
      chk("wide.almost_full", 32'(w_almost_full), 32'(m >= 6));
      chk("wide.ssptxintr", 32'(w_ssptxintr), 32'(m == 8));
    end
    w_psel = 0; w_pwrite = 0; w_t_en = 0;
    chk("wide.all_written", 32'(written), 32'd20);
    chk("wide.drained", 32'(w_count), 32'd0);
    chk("wide.txdata_hold", 32'(w_txdata), 32'(exp_tx));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
